// File: rtl/jpeg_rgb2ycc_blk_if.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_rgb2ycc_blk_if
// Brief    : Pixel-in / YCbCr-out stream bundle for the RGB-to-YCbCr front end.
// Revision : 1.0
// ============================================================================
interface jpeg_rgb2ycc_blk_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0]        R;
    logic [PIX_W-1:0]        G;
    logic [PIX_W-1:0]        B;
    logic                    pixel_valid;
    logic                    pixel_ready;
    logic signed [PIX_W-1:0] y;
    logic signed [PIX_W-1:0] cb;
    logic signed [PIX_W-1:0] cr;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [9:0]              blk_idx;

    // Source/sink side: drives pixels and accepts results.
    modport master (
        output R, G, B, pixel_valid, out_ready,
        input  pixel_ready, y, cb, cr, out_valid, out_last, blk_idx
    );

    modport slave (
        input  R, G, B, pixel_valid, out_ready,
        output pixel_ready, y, cb, cr, out_valid, out_last, blk_idx
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_rgb2ycc_blk.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_rgb2ycc_blk
// Brief    : Start-triggered RGB-to-YCbCr conversion of NUM_BLOCKS 8x8 blocks.
// Revision : 1.0
// ============================================================================
module jpeg_rgb2ycc_blk #(
    parameter int PIX_W      = 8,
    parameter int NUM_BLOCKS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               gray_mode_i,
    output logic               busy_o,
    output logic               done_o,
    jpeg_rgb2ycc_blk_if.slave  bus
);

    localparam int IW = PIX_W + 10;
    localparam int PW = PIX_W + 8;

    localparam logic [16:0]          c_last_pix = 17'(NUM_BLOCKS * 64 - 1);
    localparam logic [9:0]           c_last_blk = 10'(NUM_BLOCKS - 1);
    localparam logic signed [IW-1:0] c_max      = IW'((1 << (PIX_W - 1)) - 1);
    localparam logic signed [IW-1:0] c_min      = ~c_max;
    localparam logic signed [IW-1:0] c_half     = IW'(1 << (PIX_W - 1));
    localparam logic signed [IW-1:0] c_rnd      = IW'(128);

    localparam logic [7:0] c_k_yr  = 8'd77;
    localparam logic [7:0] c_k_yg  = 8'd150;
    localparam logic [7:0] c_k_yb  = 8'd29;
    localparam logic [7:0] c_k_cbr = 8'd43;
    localparam logic [7:0] c_k_cbg = 8'd85;
    localparam logic [7:0] c_k_cbb = 8'd128;
    localparam logic [7:0] c_k_crr = 8'd128;
    localparam logic [7:0] c_k_crg = 8'd107;
    localparam logic [7:0] c_k_crb = 8'd21;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [16:0]             in_cnt_q;
    logic [5:0]              pix_idx_q;
    logic [9:0]              blk_idx_q;
    logic                    gray_q;
    logic                    s1_v_q;
    logic                    s2_v_q;
    logic [8:0][PW-1:0]      prod_q, prod_d;
    logic signed [PIX_W-1:0] y_q, cb_q, cr_q;

    logic                    w_stall;
    logic                    w_pix_ready;
    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_out_last;
    logic signed [IW-1:0]    w_ysum, w_cbsum, w_crsum;
    logic signed [PIX_W-1:0] w_y, w_cb, w_cr;

    function automatic logic signed [IW-1:0] ext(input logic [PW-1:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic signed [PIX_W-1:0] sat(input logic signed [IW-1:0] v);
        if (v > c_max)
            return c_max[PIX_W-1:0];
        else if (v < c_min)
            return c_min[PIX_W-1:0];
        else
            return v[PIX_W-1:0];
    endfunction

    // A held output freezes both stages, so stage 1 can only advance with stage 2.
    assign w_stall     = s2_v_q & ~bus.out_ready;
    assign w_pix_ready = (state_q == S_RUN) & ~w_stall;
    assign w_accept    = bus.pixel_valid & w_pix_ready;
    assign w_out_hs    = s2_v_q & bus.out_ready;
    assign w_out_last  = s2_v_q & (pix_idx_q == 6'd63);

    always_comb begin
        prod_d[0] = PW'(bus.R) * PW'(c_k_yr);
        prod_d[1] = PW'(bus.G) * PW'(c_k_yg);
        prod_d[2] = PW'(bus.B) * PW'(c_k_yb);
        prod_d[3] = PW'(bus.R) * PW'(c_k_cbr);
        prod_d[4] = PW'(bus.G) * PW'(c_k_cbg);
        prod_d[5] = PW'(bus.B) * PW'(c_k_cbb);
        prod_d[6] = PW'(bus.R) * PW'(c_k_crr);
        prod_d[7] = PW'(bus.G) * PW'(c_k_crg);
        prod_d[8] = PW'(bus.B) * PW'(c_k_crb);
    end

    always_comb begin
        w_ysum  = ext(prod_q[0]) + ext(prod_q[1]) + ext(prod_q[2]) + c_rnd;
        w_cbsum = ext(prod_q[5]) - ext(prod_q[3]) - ext(prod_q[4]) + c_rnd;
        w_crsum = ext(prod_q[6]) - ext(prod_q[7]) - ext(prod_q[8]) + c_rnd;
        w_y     = sat((w_ysum >>> 8) - c_half);
        w_cb    = sat(w_cbsum >>> 8);
        w_cr    = sat(w_crsum >>> 8);
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != S_IDLE);
        done_o  = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (w_accept && (in_cnt_q == c_last_pix)) state_d = S_DRAIN;
            S_DRAIN: if (w_out_hs && w_out_last && (blk_idx_q == c_last_blk)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            pix_idx_q <= '0;
            blk_idx_q <= '0;
            gray_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            prod_q    <= '0;
            y_q       <= '0;
            cb_q      <= '0;
            cr_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start_i) begin
                in_cnt_q  <= '0;
                pix_idx_q <= '0;
                blk_idx_q <= '0;
                gray_q    <= gray_mode_i;
            end else begin
                if (w_accept)
                    in_cnt_q <= in_cnt_q + 17'd1;
                if (w_out_hs) begin
                    if (w_out_last) begin
                        pix_idx_q <= '0;
                        blk_idx_q <= blk_idx_q + 10'd1;
                    end else begin
                        pix_idx_q <= pix_idx_q + 6'd1;
                    end
                end
            end
            if (!w_stall) begin
                s1_v_q <= w_accept;
                s2_v_q <= s1_v_q;
                if (w_accept)
                    prod_q <= prod_d;
                if (s1_v_q) begin
                    y_q  <= w_y;
                    cb_q <= gray_q ? '0 : w_cb;
                    cr_q <= gray_q ? '0 : w_cr;
                end
            end
        end
    end

    assign bus.pixel_ready = w_pix_ready;
    assign bus.y           = y_q;
    assign bus.cb          = cb_q;
    assign bus.cr          = cr_q;
    assign bus.out_valid   = s2_v_q;
    assign bus.out_last    = w_out_last;
    assign bus.blk_idx     = blk_idx_q;

endmodule
`default_nettype wire
